// File: rtl/sha_uart_host.sv
// Host-side SHA-256 UART initiator: sends one message block byte by byte, then collects the digest.
// Optional response timeout is enabled with the SHA_HOST_TIMEOUT_EN macro.
module sha_uart_host #(
    parameter int MSG_BYTES      = 64,
    parameter int DIG_BYTES      = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_fStart,
    input  logic [8*MSG_BYTES-1:0] i_Block,
    output logic                   o_fBusy,
    output logic                   o_fDone,
    output logic                   o_fErr,
    output logic [8*DIG_BYTES-1:0] o_Digest,
    output logic                   o_TX_fTX,
    output logic [7:0]             o_TX_Data,
    input  logic                   i_TX_fReady,
    input  logic                   i_TX_fDone,
    input  logic                   i_RX_fDone,
    input  logic [7:0]             i_RX_Data
);

    localparam int MW  = 8 * MSG_BYTES;
    localparam int DW  = 8 * DIG_BYTES;
    localparam int TCW = $clog2(MSG_BYTES) + 1;
    localparam int RCW = $clog2(DIG_BYTES) + 1;
    localparam logic [TCW-1:0] TX_LAST = TCW'(MSG_BYTES - 1);
    localparam logic [RCW-1:0] RX_LAST = RCW'(DIG_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_TX,
        RECV,
        DONE
    } state_t;

    state_t         state;
    logic [MW-1:0]  shift;
    logic [TCW-1:0] tx_cnt;
    logic [RCW-1:0] rx_cnt;

`ifdef SHA_HOST_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);

    logic [TOW-1:0] to_cnt;
    logic           err;

    assign o_fErr = err;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign o_fErr = 1'b0;
`endif

    // Transaction FSM: send block MSB byte first, then shift response bytes into the digest
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state     <= IDLE;
            shift     <= '0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            o_Digest  <= '0;
            o_fBusy   <= 1'b0;
            o_fDone   <= 1'b0;
            o_TX_fTX  <= 1'b0;
            o_TX_Data <= '0;
`ifdef SHA_HOST_TIMEOUT_EN
            to_cnt    <= '0;
            err       <= 1'b0;
`endif
        end else begin
            o_fDone  <= 1'b0;
            o_TX_fTX <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_fStart) begin
                        shift    <= i_Block;
                        tx_cnt   <= '0;
                        rx_cnt   <= '0;
                        o_Digest <= '0;
                        o_fBusy  <= 1'b1;
`ifdef SHA_HOST_TIMEOUT_EN
                        err      <= 1'b0;
`endif
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (i_TX_fReady) begin
                        o_TX_fTX  <= 1'b1;
                        o_TX_Data <= shift[MW-1 -: 8];
                        state     <= WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    if (i_TX_fDone) begin
                        shift  <= {shift[MW-9:0], 8'h00};
                        tx_cnt <= tx_cnt + 1'b1;
                        if (tx_cnt == TX_LAST) begin
                            state <= RECV;
`ifdef SHA_HOST_TIMEOUT_EN
                            to_cnt <= '0;
`endif
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                RECV: begin
                    if (i_RX_fDone) begin
                        o_Digest <= {o_Digest[DW-9:0], i_RX_Data};
                        rx_cnt   <= rx_cnt + 1'b1;
`ifdef SHA_HOST_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                        if (rx_cnt == RX_LAST) begin
                            o_fDone <= 1'b1;
                            state   <= DONE;
                        end
`ifdef SHA_HOST_TIMEOUT_EN
                    end else if (to_cnt == TO_LAST) begin
                        err     <= 1'b1;
                        o_fDone <= 1'b1;
                        state   <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    o_fBusy <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_uart_host.sv
// Bench for sha_uart_host: UART TX/RX behavioural models, transaction-level reference model,
// per-cycle output compare plus literal checks of known vectors.
module tb_sha_uart_host;

    localparam int MB = 64;
    localparam int DB = 32;
    localparam int TO = 100;

    localparam logic [511:0] LIT_BLK = 512'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F202122232425262728292A2B2C2D2E2F303132333435363738393A3B3C3D3E3F;
    localparam logic [255:0] LIT_DIG = 256'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAFB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;

    logic         clk = 1'b0;
    logic         i_Rst = 1'b1;
    logic         i_fStart = 1'b0;
    logic [511:0] i_Block = '0;
    logic         o_fBusy, o_fDone, o_fErr;
    logic [255:0] o_Digest;
    logic         o_TX_fTX;
    logic [7:0]   o_TX_Data;
    logic         i_TX_fReady = 1'b0;
    logic         i_TX_fDone = 1'b0;
    logic         i_RX_fDone = 1'b0;
    logic [7:0]   i_RX_Data = '0;

    always #5 clk = ~clk;

    sha_uart_host #(
        .MSG_BYTES(MB),
        .DIG_BYTES(DB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_Clk(clk),
        .i_Rst(i_Rst),
        .i_fStart(i_fStart),
        .i_Block(i_Block),
        .o_fBusy(o_fBusy),
        .o_fDone(o_fDone),
        .o_fErr(o_fErr),
        .o_Digest(o_Digest),
        .o_TX_fTX(o_TX_fTX),
        .o_TX_Data(o_TX_Data),
        .i_TX_fReady(i_TX_fReady),
        .i_TX_fDone(i_TX_fDone),
        .i_RX_fDone(i_RX_fDone),
        .i_RX_Data(i_RX_Data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // reference model (transaction level): 0 idle, 1 sending, 2 receiving, 3 done
    int           m_phase = 0;
    logic         m_busy = 0, m_done = 0, m_err = 0;
    logic [255:0] m_dig = '0;
    logic [511:0] m_blk = '0;
    int           m_txi = 0, m_rx = 0, m_to = 0;

    // environment state
    bit   hold = 0;
    int   stray_req = 0;
    int   rsp_left = 0;
    bit   rsp_fixed = 0;
    int   rsp_idx = 0;
    int   gap = 0;
    bit   inflight = 0;
    int   tx_delay = 0;
    logic [7:0] tx_byte = '0;
    int   tx_seen = 0;
    bit   prev_ready = 0;
    int   cyc = 0;
    int   b10_cyc = -1;
    int   done_cyc = -1;
    int   n_done = 0;

    task automatic model_step();
        if (i_Rst) begin
            m_phase = 0;
            m_busy  = 0;
            m_done  = 0;
            m_err   = 0;
            m_dig   = '0;
        end else begin
            case (m_phase)
                0: begin
                    m_done = 0;
                    if (i_fStart) begin
                        m_blk   = i_Block;
                        m_dig   = '0;
                        m_err   = 0;
                        m_busy  = 1;
                        m_txi   = 0;
                        m_rx    = 0;
                        tx_seen = 0;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (i_TX_fDone) begin
                        m_txi++;
                        if (m_txi == MB) begin
                            m_phase = 2;
                            m_to    = 0;
                        end
                    end
                end
                2: begin
                    if (i_RX_fDone) begin
                        m_dig = {m_dig[247:0], i_RX_Data};
                        m_rx++;
                        m_to = 0;
                        if (m_rx == 10) b10_cyc = cyc + 1;
                        if (m_rx == DB) begin
                            m_done  = 1;
                            m_phase = 3;
                        end
`ifdef SHA_HOST_TIMEOUT_EN
                    end else if (m_to == TO - 1) begin
                        m_err   = 1;
                        m_done  = 1;
                        m_phase = 3;
                    end else begin
                        m_to++;
`endif
                    end
                end
                default: begin
                    m_done  = 0;
                    m_busy  = 0;
                    m_phase = 0;
                end
            endcase
        end
    endtask

    // per-cycle compare, UART models, then model advance for the coming edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            chk("busy", 256'(o_fBusy), 256'(m_busy));
            chk("done", 256'(o_fDone), 256'(m_done));
            chk("err", 256'(o_fErr), 256'(m_err));
            chk("digest", o_Digest, m_dig);
            if (o_fDone) begin
                n_done++;
                done_cyc = cyc;
            end
            if (o_TX_fTX) begin
                chk("tx_overlap", 256'(inflight), 256'(0));
                chk("tx_ready", 256'(prev_ready), 256'(1));
                if (tx_seen < MB)
                    chk("tx_byte", 256'(o_TX_Data), 256'(m_blk[511-8*tx_seen -: 8]));
                else
                    chk("tx_extra", 256'(tx_seen), 256'(MB - 1));
                inflight = 1;
                tx_byte  = o_TX_Data;
                tx_delay = $urandom_range(2, 8);
                tx_seen++;
            end else if (inflight) begin
                chk("tx_stable", 256'(o_TX_Data), 256'(tx_byte));
            end

            i_TX_fDone = 0;
            i_RX_fDone = 0;
            i_RX_Data  = 8'($urandom);
            if (inflight && !o_TX_fTX) begin
                if (tx_delay == 0) begin
                    i_TX_fDone = 1;
                    inflight   = 0;
                end else begin
                    tx_delay--;
                end
            end
            i_TX_fReady = !inflight && !hold;
            prev_ready  = i_TX_fReady;

            if (m_phase == 1 && stray_req > 0 && $urandom_range(0, 3) == 0) begin
                i_RX_fDone = 1;
                stray_req--;
            end else if (m_phase == 2 && rsp_left > 0) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    i_RX_fDone = 1;
                    i_RX_Data  = rsp_fixed ? 8'hA0 + 8'(rsp_idx) : 8'($urandom);
                    rsp_idx++;
                    rsp_left--;
                    gap = $urandom_range(0, 4);
                end
            end

            model_step();
        end
    end

    task automatic rand_blk(output logic [511:0] b);
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    endtask

    task automatic start_txn(input logic [511:0] blk, input int nrsp, input bit fixed,
                             input int hold_cyc, input int stray, input bit poke);
        logic [511:0] junk;
        i_Block   = blk;
        rsp_left  = nrsp;
        rsp_fixed = fixed;
        rsp_idx   = 0;
        gap       = 1;
        hold      = hold_cyc > 0;
        stray_req = stray;
        n_done    = 0;
        i_fStart  = 1;
        @(posedge clk); #2;
        i_fStart = 0;
        rand_blk(junk);
        i_Block = junk;
        if (hold_cyc > 0) begin
            repeat (hold_cyc) begin
                @(posedge clk); #2;
            end
            chk("hold_no_tx", 256'(tx_seen), 256'(0));
            hold = 0;
        end
        if (poke) begin
            repeat (20) begin
                @(posedge clk); #2;
            end
            i_fStart = 1;
            @(posedge clk); #2;
            i_fStart = 0;
        end
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(posedge clk); #2;
            if (o_fDone) seen = 1;
        end
        if (!seen) chk("done_timeout", 256'(0), 256'(1));
        repeat (3) begin
            @(posedge clk); #2;
        end
    endtask

    logic [511:0] blk;

    initial begin
        // reset with start held
        i_fStart = 1;
        repeat (2) begin
            @(posedge clk); #2;
        end
        chk("rst_busy", 256'(o_fBusy), 256'(0));
        chk("rst_done", 256'(o_fDone), 256'(0));
        chk("rst_err", 256'(o_fErr), 256'(0));
        chk("rst_digest", o_Digest, 256'(0));
        chk("rst_tx", 256'(o_TX_fTX), 256'(0));
        i_fStart = 0;
        @(posedge clk); #2;
        i_Rst = 0;
        repeat (3) begin
            @(posedge clk); #2;
        end

        // known vector
        start_txn(LIT_BLK, DB, 1, 0, 0, 0);
        wait_done(5000);
        chk("t2_digest", o_Digest, LIT_DIG);
        chk("t2_err", 256'(o_fErr), 256'(0));
        chk("t2_ntx", 256'(tx_seen), 256'(MB));
        chk("t2_ndone", 256'(n_done), 256'(1));

        // TX not ready for 50 cycles
        rand_blk(blk);
        start_txn(blk, DB, 0, 50, 0, 0);
        wait_done(5000);
        chk("t3_ntx", 256'(tx_seen), 256'(MB));
        chk("t3_ndone", 256'(n_done), 256'(1));

        // stray RX bytes and start while busy
        rand_blk(blk);
        start_txn(blk, DB, 0, 0, 3, 1);
        wait_done(5000);
        chk("t4_strays", 256'(stray_req), 256'(0));
        chk("t4_ntx", 256'(tx_seen), 256'(MB));
        chk("t4_ndone", 256'(n_done), 256'(1));

`ifdef SHA_HOST_TIMEOUT_EN
        // response stops after 10 bytes
        rand_blk(blk);
        start_txn(blk, 10, 1, 0, 0, 0);
        wait_done(6000);
        chk("t5_err", 256'(o_fErr), 256'(1));
        chk("t5_latency", 256'(done_cyc - b10_cyc), 256'(TO));
        chk("t5_partial", o_Digest, 256'(80'hA0A1A2A3A4A5A6A7A8A9));
        chk("t5_ndone", 256'(n_done), 256'(1));
`endif

        // reset during RECV after 5 bytes
        rand_blk(blk);
        start_txn(blk, 5, 0, 0, 0, 0);
        begin
            bit got;
            got = 0;
            for (int k = 0; k < 5000 && !got; k++) begin
                @(posedge clk); #2;
                if (m_rx >= 5 && m_phase == 2) got = 1;
            end
            if (!got) chk("t6_wait", 256'(0), 256'(1));
        end
        i_Rst = 1;
        @(posedge clk); #2;
        i_Rst = 0;
        chk("t6_busy", 256'(o_fBusy), 256'(0));
        chk("t6_digest", o_Digest, 256'(0));
        repeat (10) begin
            @(posedge clk); #2;
        end
        chk("t6_nodone", 256'(n_done), 256'(0));
        rand_blk(blk);
        start_txn(blk, DB, 0, 0, 0, 0);
        wait_done(5000);
        chk("t6_ndone", 256'(n_done), 256'(1));
        chk("t6_err", 256'(o_fErr), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
